// File: rtl/coordinate_reader_if.sv
// -----------------------------------------------------------------------------
// coordinate_reader_if
//
// Groups the two buses around the coordinate reader:
//   - the memory read bus: address/rd_en out to both coordinate memories,
//     x_mem_q/y_mem_q back (valid one cycle after rd_en)
//   - the downstream coordinate stream: x_out/y_out/valid/last out, ready in
//
// Modports:
//   master : the reader (drives address, rd_en, x_out, y_out, valid, last)
//   slave  : memories + pathfinding core (drive x_mem_q, y_mem_q, ready)
// -----------------------------------------------------------------------------
interface coordinate_reader_if #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 8
);
    logic [ADDR_W-1:0]  address;
    logic               rd_en;
    logic [COORD_W-1:0] x_mem_q;
    logic [COORD_W-1:0] y_mem_q;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;
    logic               valid;
    logic               ready;
    logic               last;

    modport master (
        output address, rd_en, x_out, y_out, valid, last,
        input  x_mem_q, y_mem_q, ready
    );

    modport slave (
        input  address, rd_en, x_out, y_out, valid, last,
        output x_mem_q, y_mem_q, ready
    );
endinterface

// File: rtl/coordinate_reader.sv
// -----------------------------------------------------------------------------
// coordinate_reader
//
// Walks addresses 0..count-1 of the X/Y coordinate memories in lockstep and
// streams each (x, y) pair downstream over valid/ready, then raises done.
// One coordinate every three cycles (REQ -> WAIT -> PRESENT) with ready high.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears all state
//   start  : begin a pass; sampled only in IDLE or DONE
//   count  : list length (0..2^ADDR_W), sampled with start
//   bus    : coordinate_reader_if.master (memory read bus + coordinate stream)
//   busy   : pass in progress (REQ, WAIT or PRESENT)
//   done   : pass complete; level until the next start or reset
//   hex0..hex5 : debug nibbles
//
// Build option:
//   COORD_READER_HEX_EN defined   -> hex0/1 = x_out lo/hi, hex2/3 = y_out lo/hi,
//                                    hex4/5 = idx lo/hi, all registered
//   COORD_READER_HEX_EN undefined -> hex0..hex5 tied to 0
// -----------------------------------------------------------------------------
module coordinate_reader #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     count,
    coordinate_reader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [3:0]          hex0,
    output logic [3:0]          hex1,
    output logic [3:0]          hex2,
    output logic [3:0]          hex3,
    output logic [3:0]          hex4,
    output logic [3:0]          hex5
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    // idx/cnt are one bit wider than the address so count = 2^ADDR_W fits.
    logic [ADDR_W:0]    idx_q, idx_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]  address_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               at_last;

    assign at_last = (idx_q == cnt_q - 1'b1);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d   = count;
                    idx_d   = '0;
                    state_d = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_PRESENT;
            S_PRESENT: begin
                if (bus.ready) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            address_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            // Address only moves when a read is about to be issued, so it
            // holds its last value whenever rd_en is low.
            if (state_d == S_REQ) begin
                address_q <= idx_d[ADDR_W-1:0];
            end
            if (state_q == S_WAIT) begin
                x_q <= bus.x_mem_q;
                y_q <= bus.y_mem_q;
            end
        end
    end

    assign bus.address = address_q;
    assign bus.rd_en   = (state_q == S_REQ);
    assign bus.x_out   = x_q;
    assign bus.y_out   = y_q;
    assign bus.valid   = (state_q == S_PRESENT);
    assign bus.last    = (state_q == S_PRESENT) && at_last;
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT) ||
                         (state_q == S_PRESENT);
    assign done        = (state_q == S_DONE);

`ifdef COORD_READER_HEX_EN
    logic [3:0] hex_q [6];

    // Mirrors x_out/y_out (loaded from the same memory data in WAIT) and idx
    // (loaded from its next value), so the nibbles track those registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) hex_q[i] <= 4'h0;
        end else begin
            if (state_q == S_WAIT) begin
                hex_q[0] <= bus.x_mem_q[3:0];
                hex_q[1] <= bus.x_mem_q[7:4];
                hex_q[2] <= bus.y_mem_q[3:0];
                hex_q[3] <= bus.y_mem_q[7:4];
            end
            hex_q[4] <= idx_d[3:0];
            hex_q[5] <= idx_d[7:4];
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
`else
    assign hex0 = 4'h0;
    assign hex1 = 4'h0;
    assign hex2 = 4'h0;
    assign hex3 = 4'h0;
    assign hex4 = 4'h0;
    assign hex5 = 4'h0;
`endif

endmodule

// File: tb/tb_coordinate_reader.sv
// -----------------------------------------------------------------------------
// tb_coordinate_reader
//
// Self-checking bench for coordinate_reader. A registered-read memory model
// answers rd_en; a monitor logs read addresses and accepted coordinates; the
// expected stream for a pass is simply memory[0..count-1] with last on the
// final entry, compared against the logs after each pass.
// -----------------------------------------------------------------------------
module tb_coordinate_reader;

    localparam int COORD_W = 8;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [ADDR_W:0] count;
    logic            busy, done;
    logic [3:0]      hex0, hex1, hex2, hex3, hex4, hex5;

    coordinate_reader_if #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

    coordinate_reader #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5)
    );

    always #5 clk = ~clk;

    // Coordinate memories: read data valid one cycle after rd_en.
    logic [COORD_W-1:0] x_mem [DEPTH];
    logic [COORD_W-1:0] y_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.x_mem_q <= x_mem[bus.address];
            bus.y_mem_q <= y_mem[bus.address];
        end
    end

    // Cycle counter and monitor (sampled on the falling edge).
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          rd_q [$];
    logic [16:0] acc_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rd_en) rd_q.push_back(int'(bus.address));
            if (bus.valid && bus.ready) begin
                acc_q.push_back({bus.last, bus.x_out, bus.y_out});
                last_acc_cyc = cyc + 1;   // number of the accepting edge
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " address"}, 32'(bus.address), 32'd0);
        check({tag, " rd_en"},   32'(bus.rd_en),   32'd0);
        check({tag, " x_out"},   32'(bus.x_out),   32'd0);
        check({tag, " y_out"},   32'(bus.y_out),   32'd0);
        check({tag, " valid"},   32'(bus.valid),   32'd0);
        check({tag, " last"},    32'(bus.last),    32'd0);
        check({tag, " busy"},    32'(busy),        32'd0);
        check({tag, " done"},    32'(done),        32'd0);
        check({tag, " hex"},     32'({hex5, hex4, hex3, hex2, hex1, hex0}), 32'd0);
    endtask

    task automatic load_random();
        for (int i = 0; i < DEPTH; i++) begin
            x_mem[i] = COORD_W'($urandom);
            y_mem[i] = COORD_W'($urandom);
        end
    endtask

    // Presents start for one edge (E0); returns just after E0.
    task automatic begin_pass(input int n);
        rd_q.delete();
        acc_q.delete();
        count = (ADDR_W+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit rand_ready);
        int i = 0;
        while (!done && i < bound) begin
            if (rand_ready) bus.ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        check({tag, " done reached"}, 32'(done), 32'd1);
        bus.ready = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int i = 0;
        while (!bus.valid && i < bound) begin
            tick();
            i++;
        end
        check({tag, " valid reached"}, 32'(bus.valid), 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int k, input int bound);
        int i = 0;
        while (acc_q.size() < k && i < bound) begin
            tick();
            i++;
        end
        check({tag, " accepted so far"}, 32'(acc_q.size()), 32'(k));
    endtask

    // Reference: a pass of n reads addresses 0..n-1 once each, in order, and
    // delivers memory[i] for each i with last only on i == n-1.
    task automatic check_pass(input string tag, input int n);
        int bad = 0;
        check({tag, " read count"},   32'(rd_q.size()),  32'(n));
        check({tag, " accept count"}, 32'(acc_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rd_q.size() && rd_q[i] != i) bad++;
            if (i < acc_q.size() && acc_q[i] !== {(i == n - 1), x_mem[i], y_mem[i]}) bad++;
        end
        check({tag, " content errors"}, 32'(bad), 32'd0);
    endtask

    task automatic check_hex(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] idx);
        logic [23:0] exp;
`ifdef COORD_READER_HEX_EN
        exp = {idx[7:4], idx[3:0], y[7:4], y[3:0], x[7:4], x[3:0]};
`else
        exp = 24'h0;
`endif
        check(tag, 32'({hex5, hex4, hex3, hex2, hex1, hex0}), 32'(exp));
    endtask

    initial begin
        int n;

        reset     = 1'b1;
        start     = 1'b0;
        count     = '0;
        bus.ready = 1'b0;
        load_random();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        // count=3, fixed list, ready high: latency and throughput
        x_mem[0] = 8'd5;   y_mem[0] = 8'd9;
        x_mem[1] = 8'd17;  y_mem[1] = 8'd200;
        x_mem[2] = 8'd255; y_mem[2] = 8'd0;
        bus.ready = 1'b1;
        begin_pass(3);
        check("t1 req rd_en",   32'(bus.rd_en),   32'd1);
        check("t1 req address", 32'(bus.address), 32'd0);
        check("t1 req busy",    32'(busy),        32'd1);
        tick();
        check("t1 wait rd_en", 32'(bus.rd_en), 32'd0);
        check("t1 wait valid", 32'(bus.valid), 32'd0);
        tick();
        check("t1 first valid", 32'(bus.valid), 32'd1);
        check("t1 first x",     32'(bus.x_out), 32'd5);
        check("t1 first y",     32'(bus.y_out), 32'd9);
        check("t1 first last",  32'(bus.last),  32'd0);
        wait_done("t1", 20, 1'b0);
        check("t1 cycles to final accept", 32'(last_acc_cyc - start_cyc), 32'd9);
        check("t1 done right after accept", 32'(cyc - last_acc_cyc), 32'd0);
        check("t1 valid after done", 32'(bus.valid), 32'd0);
        check("t1 busy after done",  32'(busy),      32'd0);
        check("t1 address held",     32'(bus.address), 32'd2);
        check_pass("t1", 3);

        // count=0: no reads, done one cycle after start
        begin_pass(0);
        check("t2 done",  32'(done),      32'd1);
        check("t2 busy",  32'(busy),      32'd0);
        check("t2 rd_en", 32'(bus.rd_en), 32'd0);
        repeat (3) tick();
        check("t2 no reads",  32'(rd_q.size()), 32'd0);
        check("t2 busy idle", 32'(busy),        32'd0);

        // count=2 with a 10-cycle stall on the first coordinate
        load_random();
        bus.ready = 1'b0;
        begin_pass(2);
        wait_valid("t3", 10);
        repeat (10) tick();
        check("t3 stall valid", 32'(bus.valid),   32'd1);
        check("t3 stall x",     32'(bus.x_out),   32'(x_mem[0]));
        check("t3 stall y",     32'(bus.y_out),   32'(y_mem[0]));
        check("t3 stall reads", 32'(rd_q.size()), 32'd1);
        bus.ready = 1'b1;
        wait_done("t3", 20, 1'b0);
        check_pass("t3", 2);

        // Reset while coordinate 2 of 4 is presented
        load_random();
        bus.ready = 1'b1;
        begin_pass(4);
        wait_acc("t4", 1, 20);
        bus.ready = 1'b0;
        wait_valid("t4", 10);
        reset = 1'b1;
        #1;
        check_cleared("t4 async reset");
        tick();
        reset = 1'b0;
        rd_q.delete();
        repeat (4) tick();
        check("t4 no reads after abort", 32'(rd_q.size()), 32'd0);
        check("t4 idle busy", 32'(busy), 32'd0);
        check("t4 idle done", 32'(done), 32'd0);
        bus.ready = 1'b1;
        begin_pass(1);
        wait_done("t4 count1", 20, 1'b0);
        check_pass("t4 count1", 1);

        // start pulsed while busy is ignored
        load_random();
        bus.ready = 1'b1;
        begin_pass(5);
        tick();
        count = 9'd2;
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        count = '0;
        wait_done("t5", 40, 1'b0);
        check_pass("t5", 5);

        // Full-depth list
        load_random();
        begin_pass(DEPTH);
        wait_done("t6", DEPTH * 3 + 20, 1'b0);
        check_pass("t6", DEPTH);

        // Debug nibbles: coordinate (0xA7,0x3C) at index 0x12
        load_random();
        x_mem[8'h12] = 8'hA7;
        y_mem[8'h12] = 8'h3C;
        bus.ready = 1'b1;
        begin_pass(8'h13);
        wait_acc("t7", 8'h12, 8'h12 * 3 + 10);
        bus.ready = 1'b0;
        wait_valid("t7", 10);
        check("t7 x",    32'(bus.x_out), 32'h0A7);
        check("t7 y",    32'(bus.y_out), 32'h03C);
        check("t7 last", 32'(bus.last),  32'd1);
        check_hex("t7 hex", 8'hA7, 8'h3C, 8'h12);
        bus.ready = 1'b1;
        wait_done("t7", 10, 1'b0);
        check_pass("t7", 8'h13);

        // Random lists with random backpressure
        for (int p = 0; p < 4; p++) begin
            load_random();
            n = int'($urandom_range(1, 16));
            bus.ready = 1'($urandom_range(0, 1));
            begin_pass(n);
            wait_done($sformatf("rand%0d", p), n * 24 + 50, 1'b1);
            check_pass($sformatf("rand%0d", p), n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coordinate_reader.md
# coordinate_reader

Read-back counterpart of the coordinate collection path. After the coordinate collector has written N (x, y) pairs into the X and Y coordinate memories, this block walks addresses 0..N-1 and reads both memories in lockstep. It then streams each pair to the pathfinding core over a valid/ready handshake, and signals completion. It sits between the coordinate memories (read port) and the pathfinding datapath.

## Interface
Parameters:
- COORD_W, 8, width of one x or y coordinate
- ADDR_W, 8, coordinate memory address width; max list length 2^ADDR_W

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  begin a read-back pass; sampled only in IDLE or DONE
- count  input  ADDR_W+1  number of stored coordinates, sampled with start; 0..2^ADDR_W
- x_mem_q  input  COORD_W  X memory read data, valid one cycle after rd_en
- y_mem_q  input  COORD_W  Y memory read data, valid one cycle after rd_en
- address  output  ADDR_W  shared read address to both memories
- rd_en  output  1  read strobe to both memories
- x_out  output  COORD_W  current x coordinate to downstream
- y_out  output  COORD_W  current y coordinate to downstream
- valid  output  1  x_out/y_out hold a coordinate
- ready  input  1  downstream accepts when valid && ready
- last  output  1  current coordinate is index count-1; qualified by valid
- busy  output  1  pass in progress (REQ, WAIT or PRESENT)
- done  output  1  pass complete; level, held until next start or reset
- hex0..hex5  output  4 each  debug nibbles (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, PRESENT, DONE.
- IDLE/DONE + start: latch count into cnt_q, clear idx, clear done. If count==0, go to DONE with done=1 on the next cycle and no memory reads; otherwise go to REQ.
- REQ: address=idx, rd_en=1 for exactly one cycle; next state WAIT.
- WAIT: at the end of the cycle, register x_mem_q/y_mem_q into x_out/y_out; next state PRESENT.
- PRESENT: valid=1; x_out, y_out and last are stable until acceptance. On valid&&ready:
  - if idx==cnt_q-1, go to DONE;
  - otherwise idx+1 and go to REQ.
- DONE: done=1, busy=0; stays until start.
- start in REQ/WAIT/PRESENT is ignored; count changes outside a start cycle are ignored.
- idx is ADDR_W+1 bits internally, so count=2^ADDR_W reads addresses 0..2^ADDR_W-1 without wrapping early. address = idx[ADDR_W-1:0].
- rd_en is 0 in every state except REQ; address holds its last value when rd_en=0.
- Reset values: address=0, rd_en=0, x_out=0, y_out=0, valid=0, last=0, busy=0, done=0, hex*=0. State returns to IDLE.
- Reset mid-pass: immediate abort with no further reads; the next pass requires a new start.

## Timing
- start sampled at edge E0. REQ is the cycle after E0, WAIT follows, and valid is first high in the third cycle after E0.
- First-coordinate latency: 3 cycles from start. Steady state: one coordinate per 3 cycles with ready held high.
- The accepting edge of the last coordinate drops valid; done=1 in the following cycle.
- ready=0 stalls indefinitely in PRESENT with no extra reads.
- ready is ignored when valid=0.

## Configuration
- COORD_READER_HEX_EN defined:
  - hex0/hex1 = x_out low/high nibble
  - hex2/hex3 = y_out low/high nibble
  - hex4/hex5 = idx low/high nibble
  - all registered, updated whenever x_out/idx update
- Not defined: hex0..hex5 are tied to 0, and the display logic is absent. Ports are always present.

## Test plan
- Reset, then count=3 with memories {(5,9),(17,200),(255,0)} and ready=1 -> valid pulses carry (5,9), (17,200), (255,0); addresses 0,1,2; last only on (255,0); done=1 after; 9 cycles from start to final acceptance.
- count=0 with start -> no rd_en ever, done=1 one cycle after start, busy stays 0.
- count=2 with ready held 0 for 10 cycles on the first coordinate -> x_out/y_out stable, rd_en asserted exactly once during the stall, pass then completes normally.
- Reset asserted in PRESENT of coordinate 2 of 4 -> all outputs 0 on the same cycle; later start with count=1 reads address 0 only.
- start pulsed while busy -> ignored, cnt_q unchanged. count=256 (ADDR_W=8) -> addresses 0..255 read once each, last at 255.
- With COORD_READER_HEX_EN, coordinate (0xA7,0x3C) at index 0x12 -> hex0=7, hex1=A, hex2=C, hex3=3, hex4=2, hex5=1. Without the macro, all hex outputs are 0.
